// File: rtl/bounce_level_ctrl.sv
// bounce_level_ctrl
//   Difficulty scheduler for the bounce game's graphics unit. It counts
//   consecutive paddle hits during play, raises the speed level every
//   HITS_PER_LEVEL hits, and freezes the graphics for BANNER_FRAMES frames
//   while a level-up banner is shown.
//
// Ports
//   clk         system clock (all state changes on its rising edge)
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per frame
//   game_start  one-cycle pulse, game FSM leaves newgame for play
//   game_over   one-cycle pulse, game FSM enters over
//   hit         one-cycle pulse, the paddle returned the ball
//   miss        one-cycle pulse, the ball was lost
//   sw_speed    base speed from the board switches (latched at game start)
//   speed       min(base + level, 3) to the graph unit
//   level       current level for the text overlay
//   hit_cnt     hits counted toward the next level
//   banner_on   high while the level-up banner is shown
//   gra_hold    freeze request ORed into the graph unit's still input
module bounce_level_ctrl #(
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 3,
  parameter int BANNER_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       hit,
  input  logic       miss,
  input  logic [1:0] sw_speed,
  output logic [1:0] speed,
  output logic [1:0] level,
  output logic [3:0] hit_cnt,
  output logic       banner_on,
  output logic       gra_hold
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BANNER = 2'd2
  } state_t;

  localparam logic [3:0] LAST_HIT  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0] TOP_LEVEL = 2'(MAX_LEVEL);
  localparam logic [7:0] FRAMES    = 8'(BANNER_FRAMES);

  state_t     r_state, w_state_next;
  logic [1:0] r_level, w_level_next;
  logic [3:0] r_hit_cnt, w_hit_cnt_next;
  logic [1:0] r_base, w_base_next;
  logic [7:0] r_frame_cnt, w_frame_cnt_next;
  logic       r_banner_on, r_gra_hold;
  logic [2:0] w_speed_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_level     <= 2'd0;
      r_hit_cnt   <= 4'd0;
      r_base      <= 2'd0;
      r_frame_cnt <= 8'd0;
      r_banner_on <= 1'b0;
      r_gra_hold  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_hit_cnt   <= w_hit_cnt_next;
      r_base      <= w_base_next;
      r_frame_cnt <= w_frame_cnt_next;
      // Flags are registered from the next state so they line up exactly
      // with the cycles the FSM spends in BANNER.
      r_banner_on <= (w_state_next == BANNER);
      r_gra_hold  <= (w_state_next == BANNER);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_level_next     = r_level;
    w_hit_cnt_next   = r_hit_cnt;
    w_base_next      = r_base;
    w_frame_cnt_next = r_frame_cnt;

    // game_over overrides everything, including a simultaneous game_start;
    // level and hit_cnt stay for the game-over display.
    if (game_over) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (game_start) begin
            w_state_next   = RUN;
            w_level_next   = 2'd0;
            w_hit_cnt_next = 4'd0;
            w_base_next    = sw_speed;
          end
        end
        RUN: begin
          // hit has priority over a simultaneous miss
          if (hit) begin
            if (r_hit_cnt < LAST_HIT) begin
              w_hit_cnt_next = r_hit_cnt + 4'd1;
            end else if (r_level < TOP_LEVEL) begin
              w_hit_cnt_next   = 4'd0;
              w_level_next     = r_level + 2'd1;
              w_frame_cnt_next = FRAMES;
              w_state_next     = BANNER;
            end else begin
              w_hit_cnt_next = 4'd0;
            end
          end else if (miss) begin
            w_hit_cnt_next = 4'd0;
          end
        end
        BANNER: begin
          // Decrement only here, so frame_cnt can never wrap below zero.
          if (frame_tick) begin
            w_frame_cnt_next = r_frame_cnt - 8'd1;
            if (r_frame_cnt == 8'd1) begin
              w_state_next = RUN;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // 3-bit sum so base + level can be saturated at 3 instead of wrapping.
  assign w_speed_sum = {1'b0, r_base} + {1'b0, r_level};
  assign speed       = (w_speed_sum > 3'd3) ? 2'd3 : w_speed_sum[1:0];
  assign level       = r_level;
  assign hit_cnt     = r_hit_cnt;
  assign banner_on   = r_banner_on;
  assign gra_hold    = r_gra_hold;

endmodule

// File: tb/tb_bounce_level_ctrl.sv
module tb_bounce_level_ctrl;

  logic       clk = 1'b0;
  logic       reset, frame_tick, game_start, game_over, hit, miss;
  logic [1:0] sw_speed;
  logic [1:0] speed, level;
  logic [3:0] hit_cnt;
  logic       banner_on, gra_hold;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bounce_level_ctrl #(
    .HITS_PER_LEVEL(5),
    .MAX_LEVEL(3),
    .BANNER_FRAMES(60)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .game_start(game_start),
    .game_over(game_over),
    .hit(hit),
    .miss(miss),
    .sw_speed(sw_speed),
    .speed(speed),
    .level(level),
    .hit_cnt(hit_cnt),
    .banner_on(banner_on),
    .gra_hold(gra_hold)
  );

  typedef struct {
    logic       rst, ft, gs, go, h, m;
    logic [1:0] sw;
    logic [1:0] e_spd, e_lvl;
    logic [3:0] e_hc;
    logic       e_ban, e_hold;
  } vec_t;

  function automatic vec_t mk(input logic rst, ft, gs, go, h, m,
                              input logic [1:0] sw, spd, lvl,
                              input logic [3:0] hc, input logic ban, hold);
    vec_t v;
    v.rst = rst; v.ft = ft; v.gs = gs; v.go = go; v.h = h; v.m = m;
    v.sw = sw; v.e_spd = spd; v.e_lvl = lvl; v.e_hc = hc;
    v.e_ban = ban; v.e_hold = hold;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare outputs.
  task automatic run_vec(input string name, input vec_t v);
    logic [9:0] act, exp_v;
    reset = v.rst; frame_tick = v.ft; game_start = v.gs; game_over = v.go;
    hit = v.h; miss = v.m; sw_speed = v.sw;
    @(posedge clk);
    #1;
    act   = {speed, level, hit_cnt, banner_on, gra_hold};
    exp_v = {v.e_spd, v.e_lvl, v.e_hc, v.e_ban, v.e_hold};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got spd=%0d lvl=%0d hc=%0d ban=%0b hold=%0b, want spd=%0d lvl=%0d hc=%0d ban=%0b hold=%0b",
               name, act[9:8], act[7:6], act[5:2], act[1], act[0],
               exp_v[9:8], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end else begin
      $display("[TB] %s: spd=%0d lvl=%0d hc=%0d ban=%0b hold=%0b ok",
               name, act[9:8], act[7:6], act[5:2], act[1], act[0]);
    end
  endtask

  // Shorthands for common one-cycle stimuli (reset, ft, gs, go, hit, miss).
  task automatic do_hit(input string name, input logic [1:0] spd, lvl,
                        input logic [3:0] hc, input logic ban);
    run_vec(name, mk(0, 0, 0, 0, 1, 0, 2'd0, spd, lvl, hc, ban, ban));
  endtask

  task automatic do_tick(input string name, input logic [1:0] spd, lvl,
                         input logic [3:0] hc, input logic ban);
    run_vec(name, mk(0, 1, 0, 0, 0, 0, 2'd0, spd, lvl, hc, ban, ban));
  endtask

  vec_t tbl[20];

  initial begin
    reset = 1'b1; frame_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
    hit = 1'b0; miss = 1'b0; sw_speed = 2'd0;

    //            rst ft gs go h  m  sw    spd   lvl   hc    ban hold
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 2'd2, 2'd2, 2'd0, 4'd0, 0, 0); // start, base=2
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd1, 0, 0); // sw change ignored
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd2, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 2'd0, 2'd2, 2'd0, 4'd3, 0, 0); // hit beats miss
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 4'd0, 0, 0); // streak broken
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd2, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd3, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd2, 2'd0, 4'd4, 0, 0); // 4 hits, no level-up
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd3, 2'd1, 4'd0, 1, 1); // level-up, banner
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd3, 2'd1, 4'd0, 1, 1); // hit in banner ignored
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd3, 2'd1, 4'd0, 1, 1); // miss in banner ignored
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd3, 2'd1, 4'd0, 0, 0); // over, level kept
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 2'd0, 2'd3, 2'd1, 4'd0, 0, 0); // over beats start
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0); // new game, base=0
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 2'd3, 2'd0, 2'd0, 4'd1, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 0, 0, 2'd3, 2'd0, 2'd0, 4'd1, 0, 0); // start in RUN ignored

    for (int i = 0; i < 20; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Full banner countdown at base 0: level 1, 60 ticks, then back to RUN.
    for (int i = 2; i <= 4; i++) do_hit($sformatf("cnt_hit%0d", i), 2'd0, 2'd0, 4'(i), 0);
    do_hit("lvl1_up", 2'd1, 2'd1, 4'd0, 1);
    for (int t = 1; t <= 59; t++) do_tick($sformatf("ban_tick%0d", t), 2'd1, 2'd1, 4'd0, 1);
    do_tick("ban_tick60", 2'd1, 2'd1, 4'd0, 0);
    do_hit("run_after_ban", 2'd1, 2'd1, 4'd1, 0);

    // game_over with 30 frames left: IDLE, hold drops, level kept.
    for (int i = 2; i <= 4; i++) do_hit($sformatf("b_hit%0d", i), 2'd1, 2'd1, 4'(i), 0);
    do_hit("lvl2_up", 2'd2, 2'd2, 4'd0, 1);
    for (int t = 1; t <= 30; t++) do_tick($sformatf("b_tick%0d", t), 2'd2, 2'd2, 4'd0, 1);
    run_vec("over_in_ban", mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd2, 2'd2, 4'd0, 0, 0));
    do_tick("idle_after_over", 2'd2, 2'd2, 4'd0, 0);

    // Reset in the middle of a banner.
    run_vec("c_start", mk(0, 0, 1, 0, 0, 0, 2'd2, 2'd2, 2'd0, 4'd0, 0, 0));
    for (int i = 1; i <= 4; i++) do_hit($sformatf("c_hit%0d", i), 2'd2, 2'd0, 4'(i), 0);
    do_hit("c_lvl1_up", 2'd3, 2'd1, 4'd0, 1);
    for (int t = 1; t <= 10; t++) do_tick($sformatf("c_tick%0d", t), 2'd3, 2'd1, 4'd0, 1);
    run_vec("rst_in_ban", mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, 0, 0));
    do_tick("idle_after_rst", 2'd0, 2'd0, 4'd0, 0);

    // Base 2 up to MAX_LEVEL: speed saturates, 20th hit gives no banner.
    run_vec("d_start", mk(0, 0, 1, 0, 0, 0, 2'd2, 2'd2, 2'd0, 4'd0, 0, 0));
    for (int l = 1; l <= 3; l++) begin
      for (int i = 1; i <= 4; i++)
        do_hit($sformatf("d_l%0d_hit%0d", l, i), (l == 1) ? 2'd2 : 2'd3, 2'(l - 1), 4'(i), 0);
      do_hit($sformatf("d_lvl%0d_up", l), 2'd3, 2'(l), 4'd0, 1);
      for (int t = 1; t <= 59; t++)
        do_tick($sformatf("d_l%0d_tick%0d", l, t), 2'd3, 2'(l), 4'd0, 1);
      do_tick($sformatf("d_l%0d_tick60", l), 2'd3, 2'(l), 4'd0, 0);
    end
    for (int i = 1; i <= 4; i++) do_hit($sformatf("d_max_hit%0d", i), 2'd3, 2'd3, 4'(i), 0);
    do_hit("d_hit20_no_ban", 2'd3, 2'd3, 4'd0, 0);
    do_tick("d_still_run", 2'd3, 2'd3, 4'd0, 0);
    do_hit("d_hit21", 2'd3, 2'd3, 4'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
